// File: rtl/cos_job_scheduler.sv
// cos_job_scheduler
//   Shares one cosine core (8.8 angle in, 8.8 cos out) between NREQ
//   requesters. Jobs are accepted with per-requester valid/ready handshakes,
//   arbitrated round-robin, issued to the core with a single-cycle start
//   pulse, and completed on core_done or on timeout. The result is returned
//   to the granted requester as a one-cycle rsp_valid pulse.
//
// Ports
//   clk, rst          rising-edge clock; synchronous active-high reset
//   req_valid[N]      requester i has a job pending
//   req_ready[N]      one-hot grant, asserted in IDLE only
//   req_x[16N]        8.8 angle per requester (bits 16i+15:16i)
//   req_y[8N]         core configuration byte per requester (bits 8i+7:8i)
//   rsp_valid[N]      one-hot, one-cycle result pulse
//   rsp_data[16]      cos result (0 on timeout), held until the next response
//   rsp_err           1 when the job timed out
//   core_start        one-cycle start pulse to the core
//   core_x, core_y    latched job operands, stable from ISSUE through WAIT
//   core_done         core result valid; only observed in WAIT
//   core_cosx         core result
//   busy              1 in every state except IDLE
module cos_job_scheduler #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  output logic [NREQ-1:0]     req_ready,
  input  logic [16*NREQ-1:0]  req_x,
  input  logic [8*NREQ-1:0]   req_y,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [15:0]         rsp_data,
  output logic                rsp_err,
  output logic                core_start,
  output logic [15:0]         core_x,
  output logic [7:0]          core_y,
  input  logic                core_done,
  input  logic [15:0]         core_cosx,
  output logic                busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      timer_q, timer_d;
  logic [IW-1:0]   last_q, last_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [15:0]     x_q, x_d;
  logic [7:0]      y_q, y_d;
  logic [15:0]     data_q, data_d;
  logic            err_q, err_d;

  // Round-robin search
  logic            gnt_found;
  logic [IW-1:0]   gnt_idx;
  logic [NREQ-1:0] shifted;
  int unsigned     cand;

  logic [7:0]      timer_inc;
  logic            timeout_hit;

  // Search starts one past the last served requester and wraps around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    shifted   = '0;
    cand      = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand    = (32'(last_q) + k) % NREQ;
      shifted = req_valid >> cand;
      if (!gnt_found && shifted[0]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

  // timer_q counts WAIT cycles already completed; the compare uses the count
  // including the current cycle so a job is aborted after TIMEOUT-1 WAIT
  // cycles, i.e. the response lands TIMEOUT cycles after core_start.
  assign timer_inc   = timer_q + 8'd1;
  assign timeout_hit = (timer_inc == 8'(TIMEOUT - 1));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (gnt_found) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (core_done || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic; strobes are masked during reset so an aborted job never
  // produces a start or response pulse in the reset cycle.
  always_comb begin
    req_ready  = '0;
    rsp_valid  = '0;
    core_start = 1'b0;
    if (!rst) begin
      if (state_q == S_IDLE && gnt_found) req_ready = NREQ'(1) << gnt_idx;
      if (state_q == S_RESP)              rsp_valid = NREQ'(1) << grant_q;
      core_start = (state_q == S_ISSUE);
    end
  end

  assign busy     = (state_q != S_IDLE);
  assign core_x   = x_q;
  assign core_y   = y_q;
  assign rsp_data = data_q;
  assign rsp_err  = err_q;

  // Datapath next-state
  always_comb begin
    timer_d = timer_q;
    last_d  = last_q;
    grant_d = grant_q;
    x_d     = x_q;
    y_d     = y_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (gnt_found) begin
          grant_d = gnt_idx;
          x_d     = req_x[32'(gnt_idx) * 16 +: 16];
          y_d     = req_y[32'(gnt_idx) * 8 +: 8];
        end
      end
      S_ISSUE: timer_d = '0;
      S_WAIT: begin
        timer_d = timer_inc;
        // done takes priority over a simultaneous timeout
        if (core_done) begin
          data_d = core_cosx;
          err_d  = 1'b0;
        end else if (timeout_hit) begin
          data_d = '0;
          err_d  = 1'b1;
        end
      end
      S_RESP:  last_d = grant_q;
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q <= '0;
      last_q  <= IW'(NREQ - 1);
      grant_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      timer_q <= timer_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      x_q     <= x_d;
      y_q     <= y_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

endmodule
